// File: rtl/ram_arbiter_pkg.sv
// Shared widths, FSM state and requester encodings for the two-client RAM arbiter.
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 10;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } req_id_t;

  // Owner of an in-flight read, carried alongside the RAM latency.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } read_tag_t;

  function automatic req_id_t other_id(input req_id_t id);
    return (id == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester's handshake bundle: the client is the master, the arbiter the slave.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant generator; on a tie the requester that did not win last goes first.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  req_id_t last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (other_id(last) == M0) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to M1 so that M0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= M1;
    end else if (accept) begin
      last <= gnt[1] ? M1 : M0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two requesters; after reset it first
// sweeps INIT_VAL into every address, then serves requests round-robin.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter bit              INIT_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      m0,
  ram_arbiter_if.slave      m1,
  output logic              init_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  state_t            state;
  logic [ADDR_W:0]   sweep_cnt;
  logic [1:0]        req_vec;
  logic [1:0]        arb_gnt;
  logic [1:0]        gnt_vec;
  logic              accept;
  req_id_t           sel_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  read_tag_t         tag0;
  read_tag_t         tag1;

  assign req_vec = {m1.req, m0.req};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .accept (accept),
    .gnt    (arb_gnt)
  );

  // Grants are suppressed while sweeping so pending requests simply wait.
  assign gnt_vec   = (state == RUN && !rst) ? arb_gnt : 2'b00;
  assign m0.gnt    = gnt_vec[0];
  assign m1.gnt    = gnt_vec[1];
  assign accept    = |(req_vec & gnt_vec);
  assign sel_id    = gnt_vec[1] ? M1 : M0;
  assign sel_we    = (sel_id == M1) ? m1.we    : m0.we;
  assign sel_addr  = (sel_id == M1) ? m1.addr  : m0.addr;
  assign sel_wdata = (sel_id == M1) ? m1.wdata : m0.wdata;

  // The extra counter bit lets the sweep stop after the last address instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_EN ? INIT : RUN;
      sweep_cnt <= '0;
      init_done <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_in    <= '0;
    end else begin
      case (state)
        INIT: begin
          if (!sweep_cnt[ADDR_W]) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= sweep_cnt[ADDR_W-1:0];
            ram_in    <= INIT_VAL;
            sweep_cnt <= sweep_cnt + 1'b1;
          end else begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          init_done <= 1'b1;
          ram_en    <= accept;
          ram_we    <= accept && sel_we;
          if (accept) begin
            ram_addr <= sel_addr;
            ram_in   <= sel_wdata;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Read owners travel two stages to line up with the registered RAM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag0      <= '0;
      tag1      <= '0;
      m0.rvalid <= 1'b0;
      m1.rvalid <= 1'b0;
      m0.rdata  <= '0;
      m1.rdata  <= '0;
    end else begin
      tag0.valid <= accept && !sel_we;
      tag0.id    <= sel_id;
      tag1       <= tag0;
      m0.rvalid  <= tag1.valid && (tag1.id == M0);
      m1.rvalid  <= tag1.valid && (tag1.id == M1);
      if (tag1.valid && tag1.id == M0) begin
        m0.rdata <= ram_out;
      end
      if (tag1.valid && tag1.id == M1) begin
        m1.rdata <= ram_out;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// two-client traffic against a memory-array and round-robin reference model.
module tb_ram_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 10;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_in;
  logic [DW-1:0] ram_out = '0;
  logic [DW-1:0] mem [DEPTH];

  int vectors     = 0;
  int miscompares = 0;
  int ref_mem [DEPTH];
  int model_last;

  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_VAL('0), .INIT_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .init_done (init_done),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_in    (ram_in),
    .ram_out   (ram_out)
  );

  // The RAM the arbiter drives: synchronous write, registered read.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_in;
      else        ram_out       <= mem[ram_addr];
    end
  end

  function automatic int model_pick(input bit r0, input bit r1);
    if (r0 && r1) return (model_last == 1) ? 0 : 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // Applies one accepted request to the reference model; returns the read data.
  function automatic int model_accept(input int w, input bit we, input int addr, input int wd);
    int d;
    d = 0;
    if (we) ref_mem[addr] = wd;
    else    d = ref_mem[addr];
    model_last = w;
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
    model_last = 1;
  endtask

  task automatic set_req(input int id, input bit req, input bit we, input int addr, input int wd);
    if (id == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr[AW-1:0]; m0_if.wdata = wd[DW-1:0];
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr[AW-1:0]; m1_if.wdata = wd[DW-1:0];
    end
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, 1'b0, 0, 0);
    set_req(1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wait_init_done(input string name);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (init_done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s: init_done=%b after %0d cycles, expected 1", name, init_done, n);
    end
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 1'b0, 5, 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({ram_en, ram_we, ram_addr, ram_in, init_done, m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: en=%b we=%b addr=%0d in=%0d done=%b gnt=%b%b rvalid=%b%b, expected all 0",
               ram_en, ram_we, ram_addr, ram_in, init_done, m1_if.gnt, m0_if.gnt, m1_if.rvalid, m0_if.rvalid);
    end
    vectors++;
    if (m0_if.rdata !== '0 || m1_if.rdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_rdata: m0=%0d m1=%0d, expected 0", m0_if.rdata, m1_if.rdata);
    end
    idle_all();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      vectors++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(i) || ram_in !== '0 ||
          m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0 || init_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL sweep[%0d]: en=%b we=%b addr=%0d in=%0d gnt=%b%b done=%b, expected 1 1 %0d 0 00 0",
                 i, ram_en, ram_we, ram_addr, ram_in, m1_if.gnt, m0_if.gnt, init_done, i);
      end
    end
    @(negedge clk);
    vectors++;
    if (init_done !== 1'b1 || ram_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sweep_end: init_done=%b ram_en=%b, expected 1 0", init_done, ram_en);
    end
  endtask

  task automatic test_write_read();
    int exp;
    @(posedge clk);
    #1 set_req(0, 1'b1, 1'b1, 3, 60);
    @(negedge clk);
    vectors++;
    if ({m1_if.gnt, m0_if.gnt} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL wr_gnt: gnt=%b, expected 01", {m1_if.gnt, m0_if.gnt});
    end
    void'(model_accept(0, 1'b1, 3, 60));
    @(posedge clk);
    #1 idle_all();
    @(negedge clk);
    vectors++;
    if ({ram_en, ram_we, ram_addr, ram_in} !== {1'b1, 1'b1, AW'(3), DW'(60)}) begin
      miscompares++;
      $display("[TB] FAIL wr_bus: en=%b we=%b addr=%0d in=%0d, expected 1 1 3 60", ram_en, ram_we, ram_addr, ram_in);
    end
    @(posedge clk);
    #1 set_req(0, 1'b1, 1'b0, 3, 0);
    @(negedge clk);
    vectors++;
    if (m0_if.gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rd_gnt: m0_gnt=%b, expected 1", m0_if.gnt);
    end
    exp = model_accept(0, 1'b0, 3, 0);
    @(posedge clk);
    #1 idle_all();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) begin
        vectors++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, AW'(3)}) begin
          miscompares++;
          $display("[TB] FAIL rd_bus: en=%b we=%b addr=%0d, expected 1 0 3", ram_en, ram_we, ram_addr);
        end
      end
      vectors++;
      if (m0_if.rvalid !== (j == 2) || m1_if.rvalid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL wr_rd_rvalid[%0d]: m0=%b m1=%b, expected %b 0", j, m0_if.rvalid, m1_if.rvalid, j == 2);
      end
      if (j == 2) begin
        vectors++;
        if (m0_if.rdata !== DW'(exp)) begin
          miscompares++;
          $display("[TB] FAIL wr_rd_data: m0_rdata=%0d, expected %0d", m0_if.rdata, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp;
    @(posedge clk);
    #1 set_req(1, 1'b1, 1'b1, 15, 100);
    @(negedge clk);
    vectors++;
    if ({m1_if.gnt, m0_if.gnt} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL b2b_wgnt: gnt=%b, expected 10", {m1_if.gnt, m0_if.gnt});
    end
    void'(model_accept(1, 1'b1, 15, 100));
    @(posedge clk);
    #1 set_req(1, 1'b1, 1'b0, 15, 0);
    @(negedge clk);
    vectors++;
    if (m1_if.gnt !== 1'b1 || {ram_en, ram_we, ram_addr, ram_in} !== {1'b1, 1'b1, AW'(15), DW'(100)}) begin
      miscompares++;
      $display("[TB] FAIL b2b_rgnt: gnt=%b en=%b we=%b addr=%0d in=%0d, expected 1 1 1 15 100",
               m1_if.gnt, ram_en, ram_we, ram_addr, ram_in);
    end
    exp = model_accept(1, 1'b0, 15, 0);
    @(posedge clk);
    #1 idle_all();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) begin
        vectors++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, AW'(15)}) begin
          miscompares++;
          $display("[TB] FAIL b2b_rbus: en=%b we=%b addr=%0d, expected 1 0 15", ram_en, ram_we, ram_addr);
        end
      end
      vectors++;
      if (m1_if.rvalid !== (j == 2) || m0_if.rvalid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_rvalid[%0d]: m1=%b m0=%b, expected %b 0", j, m1_if.rvalid, m0_if.rvalid, j == 2);
      end
      if (j == 2) begin
        vectors++;
        if (m1_if.rdata !== DW'(exp)) begin
          miscompares++;
          $display("[TB] FAIL b2b_data: m1_rdata=%0d, expected %0d", m1_if.rdata, exp);
        end
      end
    end
  endtask

  task automatic test_alternate();
    int w;
    int acc [8];
    int dat [8];
    @(posedge clk);
    #1 set_req(0, 1'b1, 1'b1, 1, 11);
    @(negedge clk);
    vectors++;
    if (m0_if.gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL alt_w0: m0_gnt=%b, expected 1", m0_if.gnt);
    end
    void'(model_accept(0, 1'b1, 1, 11));
    @(posedge clk);
    #1 begin set_req(0, 1'b0, 1'b0, 0, 0); set_req(1, 1'b1, 1'b1, 200, 222); end
    @(negedge clk);
    vectors++;
    if (m1_if.gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL alt_w1: m1_gnt=%b, expected 1", m1_if.gnt);
    end
    void'(model_accept(1, 1'b1, 200, 222));
    @(posedge clk);
    #1 begin set_req(0, 1'b1, 1'b0, 1, 0); set_req(1, 1'b1, 1'b0, 200, 0); end
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (t < 8) begin
        w = model_pick(1'b1, 1'b1);
        vectors++;
        if ({m1_if.gnt, m0_if.gnt} !== {w == 1, w == 0}) begin
          miscompares++;
          $display("[TB] FAIL alt_gnt[%0d]: gnt=%b, expected m%0d", t, {m1_if.gnt, m0_if.gnt}, w);
        end
        acc[t] = w;
        dat[t] = model_accept(w, 1'b0, (w == 0) ? 1 : 200, 0);
      end
      vectors++;
      if (t >= 3 && t < 11) begin
        if ({m1_if.rvalid, m0_if.rvalid} !== {acc[t-3] == 1, acc[t-3] == 0} ||
            ((acc[t-3] == 0) ? m0_if.rdata : m1_if.rdata) !== DW'(dat[t-3])) begin
          miscompares++;
          $display("[TB] FAIL alt_rd[%0d]: rvalid=%b rdata0=%0d rdata1=%0d, expected m%0d data %0d",
                   t, {m1_if.rvalid, m0_if.rvalid}, m0_if.rdata, m1_if.rdata, acc[t-3], dat[t-3]);
        end
      end else if ({m1_if.rvalid, m0_if.rvalid} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL alt_rd[%0d]: rvalid=%b, expected 00", t, {m1_if.rvalid, m0_if.rvalid});
      end
      if (t == 7) begin
        @(posedge clk);
        #1 idle_all();
      end
    end
  endtask

  task automatic test_random(input int n);
    bit p_req [2];
    bit p_we [2];
    int p_addr [2];
    int p_wd [2];
    bit e_v [4];
    int e_id [4];
    int e_d [4];
    int w, s, ns;
    bit ev, rv;
    logic [DW-1:0] rd;
    for (int i = 0; i < 2; i++) begin p_req[i] = 0; p_we[i] = 0; p_addr[i] = 0; p_wd[i] = 0; end
    for (int i = 0; i < 4; i++) begin e_v[i] = 0; e_id[i] = 0; e_d[i] = 0; end
    idle_all();
    for (int t = 0; t < n + 8; t++) begin
      @(negedge clk);
      w = model_pick(p_req[0], p_req[1]);
      vectors++;
      if ({m1_if.gnt, m0_if.gnt} !== {w == 1, w == 0}) begin
        miscompares++;
        $display("[TB] FAIL rand_gnt[%0d]: gnt=%b, expected winner %0d", t, {m1_if.gnt, m0_if.gnt}, w);
      end
      s = t % 4;
      for (int id = 0; id < 2; id++) begin
        ev = e_v[s] && (e_id[s] == id);
        rv = (id == 0) ? m0_if.rvalid : m1_if.rvalid;
        rd = (id == 0) ? m0_if.rdata : m1_if.rdata;
        vectors++;
        if (rv !== ev || (ev && rd !== DW'(e_d[s]))) begin
          miscompares++;
          $display("[TB] FAIL rand_rd[%0d] m%0d: rvalid=%b rdata=%0d, expected %b %0d", t, id, rv, rd, ev, e_d[s]);
        end
      end
      e_v[s] = 0;
      if (w >= 0) begin
        ns = (t + 3) % 4;
        e_d[ns]  = model_accept(w, p_we[w], p_addr[w], p_wd[w]);
        e_v[ns]  = !p_we[w];
        e_id[ns] = w;
        p_req[w] = 0;
      end
      @(posedge clk);
      #1;
      for (int id = 0; id < 2; id++) begin
        if (!p_req[id] && t < n && $urandom_range(1, 0) == 1) begin
          p_req[id]  = 1'b1;
          p_we[id]   = bit'($urandom_range(1, 0));
          p_addr[id] = int'($urandom_range(7, 0));
          p_wd[id]   = int'($urandom_range(1023, 0));
        end
      end
      set_req(0, p_req[0], p_we[0], p_addr[0], p_wd[0]);
      set_req(1, p_req[1], p_we[1], p_addr[1], p_wd[1]);
    end
    idle_all();
  endtask

  task automatic test_mid_reset();
    @(posedge clk);
    #1 set_req(0, 1'b1, 1'b0, 3, 0);
    @(negedge clk);
    vectors++;
    if (m0_if.gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_gnt: m0_gnt=%b, expected 1", m0_if.gnt);
    end
    @(posedge clk);
    #1 begin rst = 1'b1; idle_all(); model_reset(); end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      vectors++;
      if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mid_rvalid[%0d]: rvalid=%b, expected 00", j, {m1_if.rvalid, m0_if.rvalid});
      end
      vectors++;
      if (j == 0 && ram_en !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mid_idle: ram_en=%b, expected 0", ram_en);
      end else if (j > 0 && {ram_en, ram_we, ram_addr} !== {1'b1, 1'b1, AW'(j - 1)}) begin
        miscompares++;
        $display("[TB] FAIL mid_sweep[%0d]: en=%b we=%b addr=%0d, expected 1 1 %0d", j, ram_en, ram_we, ram_addr, j - 1);
      end
    end
    wait_init_done("mid_done");
  endtask

  task automatic test_init_request();
    int exp;
    int n;
    @(posedge clk);
    #1 set_req(0, 1'b1, 1'b1, 68, 777);
    @(negedge clk);
    vectors++;
    if (m0_if.gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ini_wgnt: m0_gnt=%b, expected 1", m0_if.gnt);
    end
    @(posedge clk);
    #1 begin idle_all(); rst = 1'b1; model_reset(); end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 set_req(0, 1'b1, 1'b0, 68, 0);
    n = 0;
    @(negedge clk);
    while (init_done !== 1'b1 && n < 400) begin
      vectors++;
      if (m0_if.gnt !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL ini_hold[%0d]: m0_gnt=%b, expected 0", n, m0_if.gnt);
      end
      @(negedge clk);
      n++;
    end
    vectors++;
    if (init_done !== 1'b1 || m0_if.gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ini_gnt: init_done=%b m0_gnt=%b after %0d cycles, expected 1 1", init_done, m0_if.gnt, n);
    end
    exp = model_accept(0, 1'b0, 68, 0);
    @(posedge clk);
    #1 idle_all();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      vectors++;
      if (m0_if.rvalid !== (j == 2) || (j == 2 && m0_if.rdata !== DW'(exp))) begin
        miscompares++;
        $display("[TB] FAIL ini_rd[%0d]: rvalid=%b rdata=%0d, expected %b %0d", j, m0_if.rvalid, m0_if.rdata, j == 2, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_all();
    model_reset();
    $display("[TB] starting ram_arbiter bench");
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alternate();
    test_random(300);
    test_mid_reset();
    test_init_request();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port 256x10 RAM (synchronous write, registered read) between two requesters, m0 and m1, using round-robin arbitration.
- After every reset it first fills the whole RAM with INIT_VAL, then serves requests.
- Sits between the RAM instance and the two client blocks. It owns every RAM control pin.

Parameters:
- ADDR_W, 8, RAM address width (depth = 2**ADDR_W).
- DATA_W, 10, RAM data width.
- INIT_VAL, 0, word written to every address during the init sweep.
- INIT_EN, 1, 1 = run the init sweep after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  m0 request valid; held until granted.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  request address.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  combinational; request accepted on the edge where req & gnt.
- m0_rvalid  out  1  one-cycle pulse: m0 read data valid.
- m0_rdata  out  DATA_W  read data, valid while m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to the m0 ports, for m1.
- init_done  out  1  high once the sweep is finished.
- ram_en  out  1  RAM enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_in  out  DATA_W  RAM write data (registered).
- ram_out  in  DATA_W  RAM read data; valid the cycle after a read strobe.

Behaviour:
- RAM contract: with ram_en=1 at edge E, a write updates mem[ram_addr] at E; a read drives ram_out from edge E onward.
- Reset values: ram_en=0, ram_we=0, ram_addr=0, ram_in=0, all gnt=0, all rvalid=0, rdata=0, init_done=0. Round-robin pointer last=1, so m0 wins the first tie.
- FSM states: INIT, RUN.
  - rst -> INIT if INIT_EN, else RUN.
  - INIT: one write per cycle (ram_en=1, ram_we=1, ram_in=INIT_VAL) to addresses 0,1,...,2**ADDR_W-1. The address counter does not wrap.
  - After the write to the last address, go to RUN. init_done rises the same cycle as the RUN entry. The sweep takes 256 cycles at default width.
  - gnt is held 0 during INIT. Requests stay pending and are not lost.
- RUN grant rules:
  - Only one requesting: that requester is granted.
  - Both requesting: grant the requester that is not `last`. `last` updates to the winner on every accept.
  - Neither requesting: no grant; pointer holds.
- Pipeline:
  - An accept at edge N registers the request onto ram_* at N, so the RAM strobes during cycle N..N+1.
  - For a read, ram_out is valid after N+1. rdata is registered at N+2 and rvalid is high for one cycle after N+2. Read latency from accept to rvalid is 2 clocks.
  - No rvalid is generated for a write.
  - A 2-deep tag pipeline carries the owner of each read, so rvalid goes to the correct requester.
  - With no accept, ram_en=0 next cycle.
- Throughput: one accept per cycle, back-to-back, with no bubbles. Reads and writes are served in accept order, so a read accepted after a write to the same address returns the new data.
- Reset mid-operation: in-flight reads are dropped (no rvalid), the tag pipeline is cleared and the sweep restarts from address 0. This holds even while in RUN.
- Requesters must hold req, we, addr and wdata stable until granted; the block does not buffer inputs.

Decomposition:
- Shared package/header holds:
  - ADDR_W and DATA_W defaults.
  - State encodings: INIT=1'b0, RUN=1'b1.
  - Requester IDs: M0=1'b0, M1=1'b1.
- One natural sub-module: rr_arb2. It is a 2-way round-robin grant generator with inputs req[1:0], an accept strobe, clk and rst, and output gnt[1:0]. It holds the `last` pointer.
- Sweep counter, ram_* registers and read-tag pipeline stay in ram_arbiter.

Test Plan:
- Reset then idle: ram_en=1, ram_we=1 for 256 consecutive cycles with addr 0..255 and ram_in=0. init_done rises on the next cycle, and gnt stays 0 throughout.
- m0 write: addr=3, wdata=60; then m0 read addr=3. m0_rvalid pulses 2 cycles after the read accept with m0_rdata=60, and m1_rvalid stays 0.
- Both hold req continuously: m0 reads addr 1, m1 reads addr 200. Grants alternate m0, m1, m0, m1 starting with m0, and each rvalid goes to the correct requester with its own data.
- Back-to-back: m1 writes addr 15 := 100, then reads addr 15 the next cycle. Expect no bubble and m1_rdata=100.
- Request during INIT: m0 reads addr 68 from cycle 5. gnt is held until init_done, then m0 is granted and m0_rdata=0.
- rst asserted one cycle after a read accept: no rvalid appears and the sweep restarts at address 0.
